operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 13 +
 rtl/operand_fetch_if.sv | 39 +++
 rtl/operand_fetch_scoreboard.sv | 28 ++
 rtl/operand_fetch.sv | 84 ++++++++
 tb/tb_operand_fetch.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared CPU widths, output-stage state type and a saturating counter helper
package operand_fetch_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int OPC_W  = 4;
    localparam int NREGS  = 1 << ADDR_W;

    typedef enum logic {EMPTY, FULL} ostate_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-side, register-file, writeback and ALU-side signals of the operand fetch stage
interface operand_fetch_if import operand_fetch_pkg::*; ();
    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  in_opcode;
    logic [ADDR_W-1:0] in_rd;
    logic [ADDR_W-1:0] in_ra;
    logic [ADDR_W-1:0] in_rb;
    logic [DATA_W-1:0] in_imm;
    logic              in_use_imm;
    logic [ADDR_W-1:0] rf_a_address;
    logic [ADDR_W-1:0] rf_b_address;
    logic [DATA_W-1:0] rf_a_data;
    logic [DATA_W-1:0] rf_b_data;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [OPC_W-1:0]  out_opcode;
    logic [ADDR_W-1:0] out_rd;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [7:0]        stall_count;

    modport slave (
        input  in_valid, in_opcode, in_rd, in_ra, in_rb, in_imm, in_use_imm,
        input  rf_a_data, rf_b_data, wb_valid, wb_rd, wb_data, out_ready,
        output in_ready, rf_a_address, rf_b_address,
        output out_valid, out_opcode, out_rd, out_a, out_b, stall_count
    );

    modport master (
        output in_valid, in_opcode, in_rd, in_ra, in_rb, in_imm, in_use_imm,
        output rf_a_data, rf_b_data, wb_valid, wb_rd, wb_data, out_ready,
        input  in_ready, rf_a_address, rf_b_address,
        input  out_valid, out_opcode, out_rd, out_a, out_b, stall_count
    );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// reg_scoreboard: busy bit per register between issue and writeback; r0 never busy
module reg_scoreboard import operand_fetch_pkg::*; (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_idx_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_idx_i,
    output logic [NREGS-1:0]  busy_o
);
    logic [NREGS-1:0] busy_q, busy_d;

    // clear first so a same-index issue overrides the writeback
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_idx_i] = 1'b0;
        if (set_i) busy_d[set_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // busy vector register
    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads sources with writeback bypass, stalls on scoreboard hazards, registers operands for the ALU
module operand_fetch import operand_fetch_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    operand_fetch_if.slave bus
);
    logic [NREGS-1:0]  busy;
    logic              wb_a, wb_b, hazard, accept;
    logic [DATA_W-1:0] src_a, src_b;
    ostate_e           state_q, state_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [7:0]        stall_q, stall_d;

    assign bus.rf_a_address = bus.in_ra;
    assign bus.rf_b_address = bus.in_rb;

    assign wb_a   = bus.wb_valid && bus.wb_rd == bus.in_ra;
    assign wb_b   = bus.wb_valid && bus.wb_rd == bus.in_rb;
    assign hazard = bus.in_valid && ((busy[bus.in_ra] && !wb_a) ||
                    (!bus.in_use_imm && busy[bus.in_rb] && !wb_b));
    assign bus.in_ready = (state_q == EMPTY || bus.out_ready) && !hazard;
    assign accept = bus.in_valid && bus.in_ready && !reset;

    assign src_a = (bus.in_ra == '0) ? '0 : wb_a ? bus.wb_data : bus.rf_a_data;
    assign src_b = bus.in_use_imm ? bus.in_imm :
                   (bus.in_rb == '0) ? '0 : wb_b ? bus.wb_data : bus.rf_b_data;

    reg_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_i     (accept && bus.in_rd != '0),
        .set_idx_i (bus.in_rd),
        .clr_i     (bus.wb_valid),
        .clr_idx_i (bus.wb_rd),
        .busy_o    (busy)
    );

    // output stage: load on accept, drain when consumed, otherwise hold
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        stall_d  = hazard ? sat_inc(stall_q) : stall_q;
        if (accept) begin
            state_d  = FULL;
            opcode_d = bus.in_opcode;
            rd_d     = bus.in_rd;
            a_d      = src_a;
            b_d      = src_b;
        end else if (state_q == FULL && bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            opcode_q <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.out_valid   = state_q == FULL;
    assign bus.out_opcode  = opcode_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_a       = a_q;
    assign bus.out_b       = b_q;
    assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and random checks of operand_fetch against a per-cycle reference model
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    operand_fetch_if bus();
    operand_fetch dut (.clk(clk), .reset(reset), .bus(bus));

    logic [DATA_W-1:0] rf [NREGS];
    assign bus.rf_a_data = rf[bus.rf_a_address];
    assign bus.rf_b_data = rf[bus.rf_b_address];

    // register file write shares the writeback bus
    always @(posedge clk) if (bus.wb_valid && bus.wb_rd != '0) rf[bus.wb_rd] <= bus.wb_data;

    logic [NREGS-1:0]  m_busy = '0;
    logic              m_valid = 1'b0;
    logic [OPC_W-1:0]  m_op = '0;
    logic [ADDR_W-1:0] m_rd = '0;
    logic [DATA_W-1:0] m_a = '0, m_b = '0;
    int                m_stall = 0;
    int                n_pass = 0, n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rd, ra, rb,
                         input logic [7:0] imm, input logic ui, input logic ordy,
                         input logic wv, input logic [2:0] wrd, input logic [7:0] wd);
        bus.in_valid = v; bus.in_opcode = op; bus.in_rd = rd; bus.in_ra = ra; bus.in_rb = rb;
        bus.in_imm = imm; bus.in_use_imm = ui; bus.out_ready = ordy;
        bus.wb_valid = wv; bus.wb_rd = wrd; bus.wb_data = wd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    function automatic logic [7:0] srcval(input logic [2:0] src);
        if (src == 0) return 8'h00;
        if (bus.wb_valid && bus.wb_rd == src) return bus.wb_data;
        return rf[src];
    endfunction

    function automatic logic pend(input logic [2:0] src);
        return m_busy[src] && !(bus.wb_valid && bus.wb_rd == src);
    endfunction

    task automatic cycle();
        logic haz, rdy, acc;
        @(negedge clk);
        haz = bus.in_valid && (pend(bus.in_ra) || (!bus.in_use_imm && pend(bus.in_rb)));
        rdy = (!m_valid || bus.out_ready) && !haz;
        acc = bus.in_valid && rdy && !reset;
        chk("in_ready", bus.in_ready, rdy);
        chk("rf_addr", {bus.rf_a_address, bus.rf_b_address}, {bus.in_ra, bus.in_rb});
        if (reset) begin
            m_busy = '0; m_valid = 0; m_op = '0; m_rd = '0; m_a = '0; m_b = '0; m_stall = 0;
        end else begin
            if (haz && m_stall < 255) m_stall++;
            if (bus.wb_valid) m_busy[bus.wb_rd] = 1'b0;
            if (acc && bus.in_rd != 0) m_busy[bus.in_rd] = 1'b1;
            if (acc) begin
                m_valid = 1; m_op = bus.in_opcode; m_rd = bus.in_rd;
                m_a = srcval(bus.in_ra);
                m_b = bus.in_use_imm ? bus.in_imm : srcval(bus.in_rb);
            end else if (bus.out_ready) m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", bus.out_valid, m_valid);
        chk("out_opcode", bus.out_opcode, m_op);
        chk("out_rd", bus.out_rd, m_rd);
        chk("out_a", bus.out_a, m_a);
        chk("out_b", bus.out_b, m_b);
        chk("stall_count", bus.stall_count, m_stall);
        chk("busy", dut.busy, m_busy);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) rf[i] <= 8'($urandom);
        rf[0] <= 8'h00; rf[1] <= 8'h12; rf[2] <= 8'h34;
        idle();
        cycle(); cycle();
        reset = 0;
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_stall", bus.stall_count, 0);

        drive(1, 4'h3, 0, 1, 2, 8'h00, 0, 1, 0, 0, 0); cycle();
        chk("basic_a", bus.out_a, 8'h12);
        chk("basic_b", bus.out_b, 8'h34);
        chk("basic_valid", bus.out_valid, 1);
        idle(); cycle();

        drive(1, 4'h1, 3, 1, 2, 8'h00, 0, 1, 0, 0, 0); cycle();
        drive(1, 4'h2, 0, 3, 2, 8'h00, 0, 1, 0, 0, 0); cycle(); cycle();
        chk("stall_two", bus.stall_count, 2);
        drive(1, 4'h2, 0, 3, 2, 8'h00, 0, 1, 1, 3, 8'h5A); cycle();
        chk("bypass_a", bus.out_a, 8'h5A);
        chk("busy3_clear", dut.busy[3], 0);
        idle(); cycle();

        drive(1, 4'h5, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0); cycle();
        drive(1, 4'h6, 0, 0, 0, 8'hEE, 0, 1, 0, 0, 0); cycle();
        chk("r0_a", bus.out_a, 0);
        chk("r0_b", bus.out_b, 0);
        chk("r0_busy", dut.busy, 0);

        drive(1, 4'h7, 0, 1, 2, 8'h00, 0, 1, 0, 0, 0); cycle();
        drive(1, 4'h8, 0, 2, 1, 8'h00, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        chk("hold_op", bus.out_opcode, 4'h7);
        bus.out_ready = 1; cycle();
        chk("resume_op", bus.out_opcode, 4'h8);
        chk("resume_a", bus.out_a, 8'h34);
        chk("resume_valid", bus.out_valid, 1);

        drive(1, 4'h9, 4, 0, 0, 8'h00, 0, 1, 1, 4, 8'h77); cycle();
        chk("set_wins", dut.busy[4], 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 8'h66); cycle();

        drive(1, 4'h1, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0); cycle();
        bus.in_rd = 2; cycle();
        bus.in_rd = 3; cycle();
        chk("busy_0e", dut.busy, 8'h0E);
        reset = 1;
        drive(1, 4'h2, 5, 0, 0, 8'h00, 0, 1, 1, 1, 8'h11); cycle();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", dut.busy, 0);
        reset = 0; idle(); cycle();

        drive(1, 4'h0, 6, 0, 0, 8'h00, 1, 1, 0, 0, 0); cycle();
        drive(1, 4'h0, 0, 6, 0, 8'h00, 1, 1, 0, 0, 0);
        repeat (260) cycle();
        chk("stall_sat", bus.stall_count, 255);
        drive(1, 4'h0, 0, 6, 0, 8'h00, 1, 1, 1, 6, 8'h42); cycle();
        chk("sat_release_a", bus.out_a, 8'h42);

        reset = 1; idle(); cycle(); reset = 0;
        repeat (600) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 3'($urandom), 3'($urandom),
                  3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) < 4), 3'($urandom), 8'($urandom));
            reset = $urandom_range(0, 99) == 0;
            cycle();
        end
        reset = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
